// File: rtl/picosoc_bus_pkg.sv
// Shared types and constants for the two-master PicoRV32 native bus arbiter.
// The state encoding doubles as the one-hot grant vector.
package picosoc_bus_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;
  localparam int BUS_SW = 4;

  localparam logic [BUS_DW-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_OWN0 = 2'b01,
    S_OWN1 = 2'b10
  } bus_state_e;

  // last_owner: 0 = master 0 held the bus last, 1 = master 1 did.
  function automatic bus_state_e arbitrate(input logic v0, input logic v1,
                                           input logic fixed_prio, input logic last_owner);
    bus_state_e pick;
    pick = S_IDLE;
    if (v0 && (!v1 || fixed_prio || last_owner)) begin
      pick = S_OWN0;
    end else if (v1) begin
      pick = S_OWN1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/picosoc_bus_timeout.sv
// Per-transaction wait counter with forced-completion strobe, plus the sticky
// timeout flag and saturating 8-bit timeout counter.
module picosoc_bus_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       wait_i,
  input  logic       req_i,
  output logic       expire_o,
  output logic       timeout_flag_o,
  output logic [7:0] timeout_count_o
);

  logic       flag_q;
  logic [7:0] err_count_q;

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      assign expire_o = 1'b0;
    end else begin : g_enabled
      localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] count_q;
      logic [CW-1:0] count_d;

      // The count never passes LAST: reaching it either expires or aborts the
      // transfer, and the following IDLE cycle clears it.
      always_comb begin
        count_d = count_q;
        if (clear_i) begin
          count_d = '0;
        end else if (wait_i) begin
          count_d = count_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          count_q <= '0;
        end else begin
          count_q <= count_d;
        end
      end

      assign expire_o = wait_i && req_i && (count_q == LAST);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      flag_q      <= 1'b0;
      err_count_q <= 8'd0;
    end else if (expire_o) begin
      flag_q <= 1'b1;
      if (err_count_q != 8'hFF) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign timeout_flag_o  = flag_q;
  assign timeout_count_o = err_count_q;

endmodule

// File: rtl/picosoc_bus_arbiter.sv
// Two-master arbiter for the PicoRV32 native bus: registered ownership,
// combinational forwarding of the owner's request, and a dead-slave timeout.
module picosoc_bus_arbiter
  import picosoc_bus_pkg::*;
#(
  parameter int                FIXED_PRIO     = 1,
  parameter int unsigned       TIMEOUT_CYCLES = 1024,
  parameter logic [BUS_DW-1:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [BUS_AW-1:0] m0_addr,
  input  logic [BUS_DW-1:0] m0_wdata,
  input  logic [BUS_SW-1:0] m0_wstrb,
  output logic [BUS_DW-1:0] m0_rdata,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [BUS_AW-1:0] m1_addr,
  input  logic [BUS_DW-1:0] m1_wdata,
  input  logic [BUS_SW-1:0] m1_wstrb,
  output logic [BUS_DW-1:0] m1_rdata,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [BUS_AW-1:0] s_addr,
  output logic [BUS_DW-1:0] s_wdata,
  output logic [BUS_SW-1:0] s_wstrb,
  input  logic [BUS_DW-1:0] s_rdata,
  output logic [1:0]        grant,
  output logic              timeout_flag,
  output logic [7:0]        timeout_count
);

  bus_state_e state_q;
  bus_state_e pick_d;
  logic [1:0] grant_q;
  logic       last_owner_q;
  logic       owner_valid;
  logic       owning;
  logic       expire;

  assign owning      = (state_q != S_IDLE);
  assign owner_valid = ((state_q == S_OWN0) && m0_valid) || ((state_q == S_OWN1) && m1_valid);
  assign pick_d      = arbitrate(m0_valid, m1_valid, FIXED_PRIO != 0, last_owner_q);

  picosoc_bus_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk             (clk),
    .reset           (reset),
    .clear_i         (!owning),
    .wait_i          (owning && !s_ready),
    .req_i           (owner_valid),
    .expire_o        (expire),
    .timeout_flag_o  (timeout_flag),
    .timeout_count_o (timeout_count)
  );

  // A forced completion only updates the counters; last_owner moves on a
  // genuine s_valid && s_ready handshake alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'b00;
      last_owner_q <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_q <= pick_d;
          grant_q <= pick_d;
        end
        S_OWN0, S_OWN1: begin
          if (!owner_valid) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
          end else if (s_ready) begin
            state_q      <= S_IDLE;
            grant_q      <= 2'b00;
            last_owner_q <= (state_q == S_OWN1);
          end else if (expire) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
          end
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  assign grant = grant_q;

  always_comb begin
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m0_rdata = '0;
    m1_ready = 1'b0;
    m1_rdata = '0;
    unique case (state_q)
      S_OWN0: begin
        s_valid  = m0_valid && !expire;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = s_ready || expire;
        m0_rdata = expire ? ERR_RDATA : s_rdata;
      end
      S_OWN1: begin
        s_valid  = m1_valid && !expire;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = s_ready || expire;
        m1_rdata = expire ? ERR_RDATA : s_rdata;
      end
      default: ;
    endcase
  end

endmodule
